// File: rtl/obd_pkg.sv
// obd_pkg
// Shared constants and types for the OBD responder slice.
//   - PID codes for the supported parameters
//   - positive / negative response codes and the "unsupported PID" NRC
//   - responder state enum and the vehicle snapshot record
package obd_pkg;

  localparam logic [7:0] PID_SPEED = 8'h0D;
  localparam logic [7:0] PID_RPM   = 8'h0C;
  localparam logic [7:0] PID_FUEL  = 8'h2F;
  localparam logic [7:0] PID_TEMP  = 8'h05;
  localparam logic [7:0] PID_ODO   = 8'h31;

  localparam logic [7:0] RSP_POS         = 8'h41;
  localparam logic [7:0] RSP_NEG         = 8'h7F;
  localparam logic [7:0] NRC_UNSUPPORTED = 8'h12;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  typedef struct packed {
    logic        engineOn;
    logic [7:0]  speed;
    logic [13:0] rpm;
    logic [7:0]  fuel;
    logic [7:0]  temp;
    logic [31:0] odometer;
  } snapshot_t;

endpackage

// File: rtl/obd_frame_builder.sv
// obd_frame_builder
// Combinational frame generator: given a vehicle snapshot, the requested PID
// and a byte index, returns the frame byte at that index and whether it is the
// final byte of the frame.
// Configuration macro: OBD_CHECKSUM_EN appends a modulo-256 checksum byte.
// Ports:
//   i_snap  - snapshotted vehicle state (including engine_on)
//   i_pid   - requested PID
//   i_index - byte position within the frame (0 = first byte)
//   o_byte  - frame byte at i_index
//   o_last  - high when i_index addresses the final frame byte
module obd_frame_builder
  import obd_pkg::*;
#(
  parameter logic [7:0] NRC_ENGINE_OFF = 8'h22
) (
  input  snapshot_t  i_snap,
  input  logic [7:0] i_pid,
  input  logic [2:0] i_index,
  output logic [7:0] o_byte,
  output logic       o_last
);

  logic [7:0] w_body [8];
  logic [2:0] w_bodyLen;
  logic       w_supported;
  logic [7:0] w_sum;

  // Frame body without checksum; unused slots stay zero so the checksum can
  // simply add up all eight entries.
  always_comb begin
    for (int i = 0; i < 8; i++) w_body[i] = 8'h00;
    w_bodyLen   = 3'd3;
    w_supported = 1'b1;
    w_body[0]   = RSP_POS;
    w_body[1]   = i_pid;
    case (i_pid)
      PID_SPEED: w_body[2] = i_snap.speed;
      PID_RPM: begin
        w_body[2] = {2'b00, i_snap.rpm[13:8]};
        w_body[3] = i_snap.rpm[7:0];
        w_bodyLen = 3'd4;
      end
      PID_FUEL: w_body[2] = i_snap.fuel;
      PID_TEMP: w_body[2] = i_snap.temp;
      PID_ODO: begin
        w_body[2] = i_snap.odometer[31:24];
        w_body[3] = i_snap.odometer[23:16];
        w_body[4] = i_snap.odometer[15:8];
        w_body[5] = i_snap.odometer[7:0];
        w_bodyLen = 3'd6;
      end
      default: w_supported = 1'b0;
    endcase
    // Unsupported PIDs take precedence over the engine-off NRC.
    if (!w_supported || !i_snap.engineOn) begin
      w_body[0] = RSP_NEG;
      w_body[2] = w_supported ? NRC_ENGINE_OFF : NRC_UNSUPPORTED;
      w_body[3] = 8'h00;
      w_body[4] = 8'h00;
      w_body[5] = 8'h00;
      w_bodyLen = 3'd3;
    end
    w_sum = 8'h00;
    for (int i = 0; i < 8; i++) w_sum = w_sum + w_body[i];
  end

  always_comb begin
`ifdef OBD_CHECKSUM_EN
    o_last = (i_index == w_bodyLen);
    o_byte = o_last ? w_sum : w_body[i_index];
`else
    o_last = (i_index == (w_bodyLen - 3'd1));
    o_byte = w_body[i_index];
`endif
  end

endmodule

// File: rtl/obd_responder.sv
// obd_responder
// Answers single-byte OBD PID requests with a byte-serial response frame
// built from a snapshot of the vehicle inputs taken at request acceptance.
// Configuration macro: OBD_CHECKSUM_EN appends a checksum byte to each frame.
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   engine_on, speed, rpm,
//   fuel, temp, odometer_raw - live vehicle state, sampled on acceptance
//   req_valid/req_data/req_ready - request handshake (PID byte)
//   rsp_valid/rsp_data/rsp_last/rsp_ready - response byte stream
module obd_responder
  import obd_pkg::*;
#(
  parameter logic [7:0] NRC_ENGINE_OFF = 8'h22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        engine_on,
  input  logic [7:0]  speed,
  input  logic [13:0] rpm,
  input  logic [7:0]  fuel,
  input  logic [7:0]  temp,
  input  logic [31:0] odometer_raw,
  input  logic        req_valid,
  input  logic [7:0]  req_data,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  input  logic        rsp_ready
);

  state_t     r_state;
  snapshot_t  r_snap;
  logic [7:0] r_pid;
  logic [2:0] r_index;
  logic       r_reqReady;
  logic       r_rspValid;
  logic [7:0] r_rspData;
  logic       r_rspLast;

  snapshot_t  w_liveSnap;
  snapshot_t  w_bldSnap;
  logic [7:0] w_bldPid;
  logic [2:0] w_bldIndex;
  logic [7:0] w_byte;
  logic       w_last;
  logic       w_idle;

  assign w_liveSnap = {engine_on, speed, rpm, fuel, temp, odometer_raw};
  assign w_idle     = (r_state == ST_IDLE);

  // The builder looks one byte ahead so the outputs can be registered: in IDLE
  // it sees the live inputs at index 0, in SEND the snapshot at the next index.
  assign w_bldSnap  = w_idle ? w_liveSnap : r_snap;
  assign w_bldPid   = w_idle ? req_data : r_pid;
  assign w_bldIndex = w_idle ? 3'd0 : (r_index + 3'd1);

  obd_frame_builder #(
    .NRC_ENGINE_OFF(NRC_ENGINE_OFF)
  ) u_builder (
    .i_snap (w_bldSnap),
    .i_pid  (w_bldPid),
    .i_index(w_bldIndex),
    .o_byte (w_byte),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_snap     <= '0;
      r_pid      <= 8'h00;
      r_index    <= 3'd0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspData  <= 8'h00;
      r_rspLast  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_reqReady) begin
            r_snap     <= w_liveSnap;
            r_pid      <= req_data;
            r_index    <= 3'd0;
            r_rspValid <= 1'b1;
            r_rspData  <= w_byte;
            r_rspLast  <= w_last;
            r_reqReady <= 1'b0;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (rsp_ready) begin
            if (r_rspLast) begin
              r_rspValid <= 1'b0;
              r_rspData  <= 8'h00;
              r_rspLast  <= 1'b0;
              r_reqReady <= 1'b1;
              r_index    <= 3'd0;
              r_state    <= ST_IDLE;
            end else begin
              r_index   <= r_index + 3'd1;
              r_rspData <= w_byte;
              r_rspLast <= w_last;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_last  = r_rspLast;

endmodule

// File: doc/obd_responder.md
OBD_RESPONDER -- requirements
Module: obd_responder

Interface
REQ-001 SHALL have parameter NRC_ENGINE_OFF, default 8'h22, the negative-response code returned while the engine is off.
REQ-002 SHALL have port clk  in  1  system clock, all logic rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port engine_on  in  1  engine running flag from vehicle physics.
REQ-005 SHALL have port speed  in  8  vehicle speed, km/h.
REQ-006 SHALL have port rpm  in  14  engine RPM.
REQ-007 SHALL have port fuel  in  8  fuel level, percent.
REQ-008 SHALL have port temp  in  8  coolant temperature.
REQ-009 SHALL have port odometer_raw  in  32  accumulated distance count.
REQ-010 SHALL have port req_valid  in  1  request byte (PID) present.
REQ-011 SHALL have port req_data  in  8  requested PID.
REQ-012 SHALL have port req_ready  out  1  responder accepts a request.
REQ-013 SHALL have port rsp_valid  out  1  response byte present.
REQ-014 SHALL have port rsp_data  out  8  response byte.
REQ-015 SHALL have port rsp_last  out  1  marks the final byte of a frame.
REQ-016 SHALL have port rsp_ready  in  1  downstream accepts the response byte.

Function
REQ-017 SHALL implement states IDLE and SEND; req_ready SHALL be 1 only in IDLE.
REQ-018 SHALL accept a request on req_valid&&req_ready, snapshot all vehicle inputs and engine_on in that cycle, and enter SEND.
REQ-019 SHALL assert rsp_valid with the first byte in the cycle after acceptance (1-cycle latency).
REQ-020 SHALL advance one byte per cycle where rsp_valid&&rsp_ready, and SHALL hold rsp_data/rsp_last stable while rsp_valid&&!rsp_ready.
REQ-021 SHALL build positive frames as 0x41, PID, data big-endian, checksum.
REQ-022 SHALL encode data as: PID 0x0D speed (1 byte); 0x0C {2'b0,rpm} (2 bytes); 0x2F fuel (1); 0x05 temp (1); 0x31 odometer_raw (4).
REQ-023 SHALL send negative frame 0x7F, PID, 0x12, checksum for any other PID.
REQ-024 SHALL send negative frame 0x7F, PID, NRC_ENGINE_OFF, checksum for a supported PID when the snapshotted engine_on is 0.
REQ-025 SHALL compute the checksum as the 8-bit modulo-256 sum of all preceding frame bytes.
REQ-026 SHALL assert rsp_last on the final byte only; after that byte is accepted it SHALL return to IDLE, with req_ready=1 the next cycle.
REQ-027 SHALL ignore input changes during SEND; frame content is the snapshot only.
REQ-028 SHALL ignore req_valid in SEND (no queueing); the requester holds it until accepted.

Reset
REQ-029 SHALL on rst, at any time including mid-frame, abort the frame, enter IDLE, and drive rsp_valid=0, rsp_data=0, rsp_last=0, req_ready=1 (asynchronously cleared; req_ready=1 from the first clock after deassertion).
REQ-030 SHALL clear the snapshot and byte index to 0 on reset.

Configuration
REQ-031 SHALL, with OBD_CHECKSUM_EN defined, append the checksum byte as the final frame byte.
REQ-032 SHALL, without OBD_CHECKSUM_EN, omit the checksum byte and set rsp_last on the last data or NRC byte.

Structure
REQ-033 SHALL take the PID constants, the 0x41/0x7F/0x12 codes and the state enum from shared package obd_pkg.
REQ-034 SHALL place PID decode and frame length/byte selection in sub-module obd_frame_builder (combinational: snapshot, PID and index in; byte and last out).

Verification (OBD_CHECKSUM_EN defined)
REQ-035 SHALL cover: engine_on=1, speed=0x64, PID 0x0D, rsp_ready=1 -> 41 0D 64 B2, rsp_last on B2, first byte 1 cycle after accept.
REQ-036 SHALL cover: rpm=3000, PID 0x0C -> 41 0C 0B B8 10.
REQ-037 SHALL cover: odometer_raw=0x00012345, PID 0x31, rsp_ready toggling 1/0 -> 41 31 00 01 23 45 DB with no byte lost or duplicated.
REQ-038 SHALL cover: PID 0x99 -> 7F 99 12 2A; engine_on=0, PID 0x0D -> 7F 0D 22 AE.
REQ-039 SHALL cover: speed changed from 0x64 to 0x10 mid-frame -> frame still carries 0x64.
REQ-040 SHALL cover: rst pulse after 2 bytes -> rsp_valid=0 immediately, req_ready=1 after release, next request yields a complete fresh frame.
